// File: rtl/protein_tarayici.sv
// Streaming protein scanner: opens a protein on a start codon, counts codons and match
// score, closes on a stop codon or length limit and reports each protein via valid/ready.
module protein_tarayici #(
  parameter int                 KODON_W      = 6,
  parameter int                 UZUNLUK_W    = 10,
  parameter int                 PUAN_W       = 16,
  parameter int                 MAX_UZUNLUK  = 1000,
  parameter int                 ESLESME_PUAN = 1,
  parameter logic [KODON_W-1:0] BASLANGIC    = 6'b000110,
  parameter logic [KODON_W-1:0] BITIS0       = 6'b011000,
  parameter logic [KODON_W-1:0] BITIS1       = 6'b010000,
  parameter logic [KODON_W-1:0] BITIS2       = 6'b010010
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [KODON_W-1:0]   kodon1,
  input  logic [KODON_W-1:0]   kodon2,
  input  logic                 kodon_gecerli,
  output logic                 kodon_hazir,
  output logic                 sonuc_gecerli,
  input  logic                 sonuc_hazir,
  output logic [PUAN_W-1:0]    puan,
  output logic [UZUNLUK_W-1:0] uzunluk,
  output logic                 neden,
  output logic                 doygun,
  output logic [7:0]           protein_sayisi
);

  typedef enum logic [1:0] {
    BEKLE = 2'd0,
    OKU   = 2'd1,
    SONUC = 2'd2
  } durum_t;

  durum_t               durum_r, durum_s;
  logic [UZUNLUK_W-1:0] uzunluk_i_r, uzunluk_i_s;
  logic [PUAN_W-1:0]    puan_i_r, puan_i_s;
  logic                 doygun_i_r, doygun_i_s;
  logic                 yukle_s, neden_s;
  logic                 kabul_s, teslim_s, durdur_s, eslesme_s, tasma_s, limit_s;
  logic [PUAN_W:0]      toplam_s;
  logic [PUAN_W-1:0]    yeni_puan_s;
  logic [UZUNLUK_W-1:0] yeni_uzunluk_s;

  logic                 kodon_hazir_r, sonuc_gecerli_r, neden_r, doygun_r;
  logic [PUAN_W-1:0]    puan_r;
  logic [UZUNLUK_W-1:0] uzunluk_r;
  logic [7:0]           sayac_r;

  assign kabul_s   = kodon_gecerli && kodon_hazir_r;
  assign teslim_s  = sonuc_gecerli_r && sonuc_hazir;
  assign durdur_s  = (kodon1 == BITIS0) || (kodon1 == BITIS1) || (kodon1 == BITIS2);
  assign eslesme_s = (kodon1 == kodon2);

  // Saturating score add: the extra top bit flags overflow past 2^PUAN_W-1.
  assign toplam_s       = {1'b0, puan_i_r} + (eslesme_s ? (PUAN_W+1)'(ESLESME_PUAN) : {(PUAN_W+1){1'b0}});
  assign tasma_s        = toplam_s[PUAN_W];
  assign yeni_puan_s    = tasma_s ? {PUAN_W{1'b1}} : toplam_s[PUAN_W-1:0];
  assign yeni_uzunluk_s = uzunluk_i_r + UZUNLUK_W'(1);
  assign limit_s        = (yeni_uzunluk_s == UZUNLUK_W'(MAX_UZUNLUK));

  // Next-state and accumulator update logic.
  always_comb begin
    durum_s     = durum_r;
    uzunluk_i_s = uzunluk_i_r;
    puan_i_s    = puan_i_r;
    doygun_i_s  = doygun_i_r;
    yukle_s     = 1'b0;
    neden_s     = 1'b0;
    case (durum_r)
      BEKLE: begin
        if (kabul_s && (kodon1 == BASLANGIC)) begin
          durum_s     = OKU;
          uzunluk_i_s = {UZUNLUK_W{1'b0}};
          puan_i_s    = {PUAN_W{1'b0}};
          doygun_i_s  = 1'b0;
        end else begin
          durum_s = BEKLE;
        end
      end
      OKU: begin
        if (kabul_s) begin
          if (durdur_s) begin
            durum_s = SONUC;
            yukle_s = 1'b1;
            neden_s = 1'b0;
          end else begin
            uzunluk_i_s = yeni_uzunluk_s;
            puan_i_s    = yeni_puan_s;
            doygun_i_s  = doygun_i_r | tasma_s;
            if (limit_s) begin
              durum_s = SONUC;
              yukle_s = 1'b1;
              neden_s = 1'b1;
            end else begin
              durum_s = OKU;
            end
          end
        end else begin
          durum_s = OKU;
        end
      end
      SONUC: begin
        if (teslim_s) begin
          durum_s = BEKLE;
        end else begin
          durum_s = SONUC;
        end
      end
      default: begin
        durum_s = BEKLE;
      end
    endcase
  end

  // State, accumulators, handshake flags and the held result fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_r         <= BEKLE;
      uzunluk_i_r     <= {UZUNLUK_W{1'b0}};
      puan_i_r        <= {PUAN_W{1'b0}};
      doygun_i_r      <= 1'b0;
      kodon_hazir_r   <= 1'b0;
      sonuc_gecerli_r <= 1'b0;
      puan_r          <= {PUAN_W{1'b0}};
      uzunluk_r       <= {UZUNLUK_W{1'b0}};
      neden_r         <= 1'b0;
      doygun_r        <= 1'b0;
      sayac_r         <= 8'd0;
    end else begin
      durum_r         <= durum_s;
      uzunluk_i_r     <= uzunluk_i_s;
      puan_i_r        <= puan_i_s;
      doygun_i_r      <= doygun_i_s;
      kodon_hazir_r   <= (durum_s != SONUC);
      sonuc_gecerli_r <= (durum_s == SONUC);
      if (yukle_s) begin
        puan_r    <= puan_i_s;
        uzunluk_r <= uzunluk_i_s;
        neden_r   <= neden_s;
        doygun_r  <= doygun_i_s;
      end
      if (teslim_s) begin
        sayac_r <= sayac_r + 8'd1;
      end
    end
  end

  assign kodon_hazir    = kodon_hazir_r;
  assign sonuc_gecerli  = sonuc_gecerli_r;
  assign puan           = puan_r;
  assign uzunluk        = uzunluk_r;
  assign neden          = neden_r;
  assign doygun         = doygun_r;
  assign protein_sayisi = sayac_r;

endmodule
